// File: rtl/vect_pkg.sv
// Shared vector-unit constants: default geometry, store FSM states, per-lane flag bit positions.
package vect_pkg;

    localparam int N_DEF  = 8;
    localparam int M_DEF  = 4;
    localparam int AW_DEF = 32;

    // Bit positions inside each lane's 4-bit {neg, zero, carry, overflow} flag nibble.
    localparam int FLAG_NEG   = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_CARRY = 1;
    localparam int FLAG_OVF   = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/vect_store_unit.sv
// Serialises a latched M-lane vector into M memory writes, one lane per accepted ack; done pulses M+1 cycles after start when ack is held high.
// mem_ack low stalls the current write with address and data held stable; start is ignored while busy.
module vect_store_unit
    import vect_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int M  = M_DEF,
    parameter int AW = AW_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [AW-1:0]          base_addr,
    input  logic [M*N-1:0]         vec_in,
    input  logic [M*4-1:0]         flags_in,
    output logic                   mem_we,
    output logic [AW-1:0]          mem_addr,
    output logic [N-1:0]           mem_wdata,
    input  logic                   mem_ack,
    output logic                   busy,
    output logic                   done,
    output logic                   any_neg,
    output logic [$clog2(M+1)-1:0] zero_count
);

    localparam int              IDXW = (M > 1) ? $clog2(M) : 1;
    localparam int              ZCW  = $clog2(M + 1);
    localparam logic [IDXW-1:0] LAST = IDXW'(M - 1);

    state_t          state, state_nxt;
    logic [IDXW-1:0] idx, idx_nxt;
    logic [AW-1:0]   base_q;
    logic [M*N-1:0]  vec_q;
    logic [M-1:0]    neg_q, zero_q;
    logic [M-1:0]    neg_in, zero_in;
    logic [ZCW-1:0]  zero_sum;
    logic            capture;
    logic            we_nxt;
    logic [AW-1:0]   addr_nxt;
    logic [N-1:0]    wdata_nxt;
    logic            done_nxt;
    logic            unused_flags;

    // Only neg and zero feed the summary outputs; carry/overflow are carried for interface parity.
    always_comb begin
        neg_in       = '0;
        zero_in      = '0;
        unused_flags = 1'b0;
        for (int i = 0; i < M; i++) begin
            neg_in[i]    = flags_in[i*4 + FLAG_NEG];
            zero_in[i]   = flags_in[i*4 + FLAG_ZERO];
            unused_flags = unused_flags ^ flags_in[i*4 + FLAG_CARRY] ^ flags_in[i*4 + FLAG_OVF];
        end
    end

    always_comb begin
        zero_sum = '0;
        for (int i = 0; i < M; i++) begin
            zero_sum = zero_sum + ZCW'(zero_q[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and next-output values; every output is then registered below.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        we_nxt    = mem_we;
        addr_nxt  = mem_addr;
        wdata_nxt = mem_wdata;
        done_nxt  = 1'b0;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    capture   = 1'b1;
                    state_nxt = ST_WRITE;
                    idx_nxt   = '0;
                    we_nxt    = 1'b1;
                    addr_nxt  = base_addr;
                    wdata_nxt = vec_in[N-1:0];
                end
            end
            ST_WRITE: begin
                if (mem_ack) begin
                    if (idx == LAST) begin
                        state_nxt = ST_DONE;
                        we_nxt    = 1'b0;
                        done_nxt  = 1'b1;
                    end else begin
                        idx_nxt   = idx + 1'b1;
                        addr_nxt  = base_q + AW'(idx_nxt);
                        wdata_nxt = vec_q[int'(idx_nxt)*N +: N];
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx        <= '0;
            base_q     <= '0;
            vec_q      <= '0;
            neg_q      <= '0;
            zero_q     <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            any_neg    <= 1'b0;
            zero_count <= '0;
        end else begin
            idx       <= idx_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            busy      <= (state_nxt != ST_IDLE);
            done      <= done_nxt;
            if (capture) begin
                base_q <= base_addr;
                vec_q  <= vec_in;
                neg_q  <= neg_in;
                zero_q <= zero_in;
            end
            // Summaries trail the capture by one cycle and stay put until the next one.
            any_neg    <= |neg_q;
            zero_count <= zero_sum;
        end
    end

endmodule

// File: tb/tb_vect_store_unit.sv
// Randomised and directed bench for vect_store_unit with a queue-based reference model.
module tb_vect_store_unit;

    localparam int N   = 8;
    localparam int M   = 4;
    localparam int AW  = 32;
    localparam int ZCW = $clog2(M + 1);

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [AW-1:0]  base_addr;
    logic [M*N-1:0] vec_in;
    logic [M*4-1:0] flags_in;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [N-1:0]   mem_wdata;
    logic           mem_ack;
    logic           busy;
    logic           done;
    logic           any_neg;
    logic [ZCW-1:0] zero_count;

    vect_store_unit #(.N(N), .M(M), .AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .vec_in     (vec_in),
        .flags_in   (flags_in),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .busy       (busy),
        .done       (done),
        .any_neg    (any_neg),
        .zero_count (zero_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [N-1:0]  data;
    } wr_t;

    // Reference model: pending writes of the current store, pending done pulse, flag summaries.
    wr_t exp_q[$];
    bit  exp_done = 0;
    bit  lat_neg = 0;
    int  lat_zc = 0;
    bit  exp_neg = 0;
    int  exp_zc = 0;
    bit  model_on = 0;
    bit  nd_tmp;
    wr_t w_tmp;

    int  start_log[$];
    int  done_log[$];
    wr_t acc_log[$];
    int  acc_cyc[$];

    always @(negedge clk) begin
        if (model_on) begin
            check("mem_we", mem_we, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                check("mem_addr", mem_addr, exp_q[0].addr);
                check("mem_wdata", mem_wdata, exp_q[0].data);
            end
            check("done", done, exp_done);
            check("busy", busy, (exp_q.size() > 0) || exp_done);
            check("any_neg", any_neg, exp_neg);
            check("zero_count", zero_count, exp_zc);
            if (mem_we && mem_ack && rst_n) begin
                acc_log.push_back('{addr: mem_addr, data: mem_wdata});
                acc_cyc.push_back(cyc);
            end
            if (done) done_log.push_back(cyc);
        end
        if (!rst_n) begin
            model_on = 1;
            exp_q.delete();
            exp_done = 0;
            lat_neg = 0;
            lat_zc = 0;
            exp_neg = 0;
            exp_zc = 0;
        end else if (model_on) begin
            nd_tmp = 0;
            exp_neg = lat_neg;
            exp_zc = lat_zc;
            if (exp_q.size() > 0) begin
                if (mem_ack) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) nd_tmp = 1;
                end
            end else if (!exp_done && start) begin
                start_log.push_back(cyc);
                for (int i = 0; i < M; i++) begin
                    w_tmp.addr = base_addr + AW'(i);
                    w_tmp.data = vec_in[i*N +: N];
                    exp_q.push_back(w_tmp);
                end
                lat_neg = 0;
                lat_zc = 0;
                for (int i = 0; i < M; i++) begin
                    lat_neg = lat_neg | flags_in[i*4 + 3];
                    lat_zc = lat_zc + int'(flags_in[i*4 + 2]);
                end
            end
            exp_done = nd_tmp;
        end
    end

    // Memory responder: 0 always ack, 1 random while writing, 2 stall at stall_addr, 3 fully random.
    int            ack_mode = 0;
    int            stall_left = 0;
    logic [AW-1:0] stall_addr = '0;

    always @(posedge clk) begin
        #1;
        case (ack_mode)
            0: mem_ack = 1'b1;
            1: mem_ack = ($urandom_range(0, 3) != 0);
            2: begin
                if (mem_we && mem_addr == stall_addr && stall_left > 0) begin
                    mem_ack = 1'b0;
                    stall_left--;
                end else begin
                    mem_ack = 1'b1;
                end
            end
            default: mem_ack = ($urandom_range(0, 1) != 0);
        endcase
    end

    task automatic store(input logic [AW-1:0] b, input logic [M*N-1:0] v, input logic [M*4-1:0] f);
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = b;
        vec_in = v;
        flags_in = f;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = $urandom;
        vec_in = $urandom;
        flags_in = 16'($urandom);
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (!done && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", done, 1'b1);
        @(posedge clk);
        #1;
    endtask

    int s0, d0, st0;
    logic [N-1:0]  lane_lit [M];
    logic [AW-1:0] wrap_lit [M];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        vec_in = '0;
        flags_in = '0;
        mem_ack = 1'b0;
        lane_lit = '{8'h11, 8'h22, 8'h33, 8'h44};
        wrap_lit = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 8'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_summary", {any_neg, zero_count}, 4'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Ack held high: four consecutive writes, done five cycles after start.
        ack_mode = 0;
        s0 = acc_log.size(); d0 = done_log.size(); st0 = start_log.size();
        store(32'h100, 32'h4433_2211, 16'h0);
        wait_done(40);
        check("t1_nwrites", acc_log.size() - s0, M);
        for (int i = 0; i < M; i++) begin
            check("t1_addr", acc_log[s0+i].addr, 32'h100 + i);
            check("t1_data", acc_log[s0+i].data, lane_lit[i]);
            check("t1_wcyc", acc_cyc[s0+i] - start_log[st0], i + 1);
        end
        check("t1_done_lat", done_log[d0] - start_log[st0], 5);

        // Three-cycle stall on lane 2 pushes lane 3 and done out by three.
        ack_mode = 2; stall_addr = 32'h102; stall_left = 3;
        s0 = acc_log.size(); d0 = done_log.size(); st0 = start_log.size();
        store(32'h100, 32'h4433_2211, 16'h0);
        wait_done(40);
        check("t2_lane2_addr", acc_log[s0+2].addr, 32'h102);
        check("t2_lane2_data", acc_log[s0+2].data, 8'h33);
        check("t2_lane2_cyc", acc_cyc[s0+2] - start_log[st0], 6);
        check("t2_lane3_cyc", acc_cyc[s0+3] - start_log[st0], 7);
        check("t2_done_lat", done_log[d0] - start_log[st0], 8);

        // Address wrap with a random responder.
        ack_mode = 1;
        s0 = acc_log.size();
        store(32'hFFFF_FFFE, $urandom, 16'h0);
        wait_done(200);
        for (int i = 0; i < M; i++) check("t3_wrap_addr", acc_log[s0+i].addr, wrap_lit[i]);

        // Flag summaries.
        ack_mode = 0;
        store(32'h200, $urandom, 16'b1000_0100_0100_0000);
        wait_done(40);
        check("t4_any_neg", any_neg, 1'b1);
        check("t4_zero_count", zero_count, 3'd2);

        // start pulses during WRITE are ignored.
        ack_mode = 1;
        s0 = acc_log.size(); d0 = done_log.size();
        store(32'h400, $urandom, 16'($urandom));
        #1 start = 1'b1; base_addr = 32'h999;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done(200);
        repeat (8) @(posedge clk);
        check("t5_nwrites", acc_log.size() - s0, M);
        check("t5_ndone", done_log.size() - d0, 1);
        check("t5_last_addr", acc_log[s0+M-1].addr, 32'h403);

        // Reset after lane 1 aborts the store.
        ack_mode = 0;
        s0 = acc_log.size(); d0 = done_log.size();
        store(32'h300, $urandom, 16'($urandom));
        @(posedge clk); #1;
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_we_after_rst", mem_we, 1'b0);
        check("t6_busy_after_rst", busy, 1'b0);
        check("t6_addr_after_rst", mem_addr, 32'h0);
        repeat (10) @(posedge clk);
        #1;
        check("t6_nwrites", acc_log.size() - s0, 2);
        check("t6_ndone", done_log.size() - d0, 0);

        // Random traffic: start/data/flags/ack noise with occasional resets.
        for (int k = 0; k < 1500; k++) begin
            @(posedge clk);
            #1;
            if (k % 300 == 0) ack_mode = (k / 300) % 2 == 0 ? 3 : 1;
            start = ($urandom_range(0, 2) == 0);
            base_addr = $urandom;
            if ($urandom_range(0, 9) == 0) base_addr = 32'hFFFF_FFFF - AW'($urandom_range(0, 3));
            vec_in = $urandom;
            flags_in = 16'($urandom);
            rst_n = ($urandom_range(0, 299) != 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1; start = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vect_store_unit.md
VECT_STORE_UNIT -- requirements
Module: vect_store_unit

Interface
REQ-001 SHALL have parameter N, default 8, lane width in bits.
REQ-002 SHALL have parameter M, default 4, number of lanes.
REQ-003 SHALL have parameter AW, default 32, memory address width.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 start  input  1  store request, sampled only in IDLE.
REQ-007 base_addr  input  AW  byte address of lane 0.
REQ-008 vec_in  input  M x N signed  result vector from the vector ALU.
REQ-009 flags_in  input  M x 4  per-lane {neg, zero, carry, overflow}.
REQ-010 mem_we  output  1  write request to data memory.
REQ-011 mem_addr  output  AW  write address.
REQ-012 mem_wdata  output  N  write data.
REQ-013 mem_ack  input  1  memory accepted the current write this cycle.
REQ-014 busy  output  1  high outside IDLE.
REQ-015 done  output  1  one-cycle completion pulse.
REQ-016 any_neg  output  1  OR of latched lane neg flags.
REQ-017 zero_count  output  $clog2(M+1)  number of latched lanes with zero flag set.

Function
REQ-018 SHALL implement FSM states IDLE, WRITE, DONE.
REQ-019 In IDLE with start=1: SHALL latch vec_in, flags_in and base_addr, clear the lane index to 0, and enter WRITE next cycle.
REQ-020 SHALL ignore start in WRITE and DONE; no queuing.
REQ-021 In WRITE: SHALL drive mem_we=1, mem_addr=latched base+index (mod 2^AW), mem_wdata=latched lane[index].
REQ-022 SHALL hold mem_addr and mem_wdata stable until mem_ack=1.
REQ-023 On mem_ack=1 with index<M-1: SHALL increment index; mem_we stays high.
REQ-024 On mem_ack=1 with index=M-1: SHALL enter DONE; mem_we=0 next cycle.
REQ-025 In DONE: SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 With mem_ack tied high: SHALL show done exactly M+1 cycles after the cycle start is sampled.
REQ-027 SHALL compute any_neg and zero_count from latched flags one cycle after capture, and hold them until the next capture.
REQ-028 Address wrap: base+index SHALL wrap modulo 2^AW silently.
REQ-029 mem_ack while mem_we=0 SHALL be ignored.
REQ-030 All outputs SHALL be registered.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force IDLE, index=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, any_neg=0, zero_count=0.
REQ-032 Reset during WRITE SHALL abort the transfer; no further writes occur and done is not asserted.
REQ-033 Reset SHALL take priority over start and mem_ack in the same cycle.

Structure
REQ-034 Package vect_pkg SHALL hold the N/M/AW defaults, the state enum and the flag bit indices (NEG=3, ZERO=2, CARRY=1, OVF=0), shared with alu_vect.
REQ-035 The block SHALL be a single module with no sub-module; lane selection is an indexed mux.

Verification
REQ-036 Store with ack always high: base=0x100, vec={0x11,0x22,0x33,0x44}, mem_ack=1 -> writes 0x11@0x100, 0x22@0x101, 0x33@0x102, 0x44@0x103 on consecutive cycles; done 5 cycles after start.
REQ-037 Stalled memory: mem_ack low for 3 cycles on lane 2 -> mem_addr=0x102 and mem_wdata=0x33 stay stable; lane 3 follows; done is delayed by 3 cycles.
REQ-038 Address wrap: base=0xFFFFFFFE, M=4 -> addresses are 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
REQ-039 Flags summary: flags_in={4'b1000, 4'b0100, 4'b0100, 4'b0000} -> any_neg=1, zero_count=2.
REQ-040 Busy and reset: start pulsed during WRITE -> ignored, exactly M writes occur; rst_n=0 after lane 1 -> mem_we=0 next cycle, no done, IDLE entered.
